// File: rtl/multiply_tokens.sv
// Serial token expander: each input token on a schedules FACTOR back-to-back output tokens on b.
// Saturating pending counter absorbs bursts; sticky overflow flags tokens lost to saturation.
module multiply_tokens #(
  parameter int FACTOR      = 2,
  parameter int MAX_PENDING = 255,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             ovf_clr,
  output logic             b,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam logic [CNT_W:0] FACTOR_V = (CNT_W + 1)'(FACTOR);
  localparam logic [CNT_W:0] MAX_V    = (CNT_W + 1)'(MAX_PENDING);

  logic             emit;
  logic [CNT_W:0]   sum;
  logic             sat;

  // One extra bit so arrival on a full counter is detected, not wrapped.
  always_comb begin
    emit = (pending != '0);
    sum  = {1'b0, pending} - {{CNT_W{1'b0}}, emit} + (a ? FACTOR_V : '0);
    sat  = (sum > MAX_V);
  end

  assign busy = emit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      b        <= 1'b0;
      overflow <= 1'b0;
    end else begin
      b <= emit;
      if (sat) begin
        pending  <= MAX_V[CNT_W-1:0];
        overflow <= 1'b1;
      end else begin
        pending <= sum[CNT_W-1:0];
        if (ovf_clr) overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiply_tokens.sv
// Directed/random bench for multiply_tokens: three instances (F=2/M=7, F=1, F=4) against a token-count model.
module tb_multiply_tokens;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_s, clr_s, a_1, a_4;
  logic       b_s, busy_s, ovf_s;
  logic [2:0] pend_s;
  logic       b_1, busy_1, ovf_1;
  logic [7:0] pend_1;
  logic       b_4, busy_4, ovf_4;
  logic [7:0] pend_4;
  logic       zero = 1'b0;

  multiply_tokens #(.FACTOR(2), .MAX_PENDING(7)) u_s (
    .clk(clk), .rst(rst), .a(a_s), .ovf_clr(clr_s),
    .b(b_s), .busy(busy_s), .pending(pend_s), .overflow(ovf_s));

  multiply_tokens #(.FACTOR(1), .MAX_PENDING(255)) u_1 (
    .clk(clk), .rst(rst), .a(a_1), .ovf_clr(zero),
    .b(b_1), .busy(busy_1), .pending(pend_1), .overflow(ovf_1));

  multiply_tokens #(.FACTOR(4), .MAX_PENDING(255)) u_4 (
    .clk(clk), .rst(rst), .a(a_4), .ovf_clr(zero),
    .b(b_4), .busy(busy_4), .pending(pend_4), .overflow(ovf_4));

  int vectors = 0;
  int miscompares = 0;

  // Reference: tokens owed per instance, plus last emitted value and sticky flag.
  int owed [3];
  int mb   [3];
  int mo   [3];
  int fac  [3] = '{2, 1, 4};
  int mx   [3] = '{7, 255, 255};
  bit a1_d1, a1_d2;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      owed[i] = 0; mb[i] = 0; mo[i] = 0;
    end
    a1_d1 = 0; a1_d2 = 0;
  endtask

  task automatic model_edge(input int i, input bit tok, input bit clr);
    int total;
    mb[i] = (owed[i] > 0);
    total = owed[i] - mb[i] + (tok ? fac[i] : 0);
    if (total > mx[i]) begin
      owed[i] = mx[i];
      mo[i]   = 1;
    end else begin
      owed[i] = total;
      if (clr) mo[i] = 0;
    end
  endtask

  task automatic check_all();
    check("s_b",    int'(b_s),    mb[0]);
    check("s_pend", int'(pend_s), owed[0]);
    check("s_ovf",  int'(ovf_s),  mo[0]);
    check("s_busy", int'(busy_s), int'(owed[0] > 0));
    check("f1_b",   int'(b_1),    mb[1]);
    check("f1_pend",int'(pend_1), owed[1]);
    check("f1_delay2", int'(b_1), int'(a1_d2));
    check("f4_b",   int'(b_4),    mb[2]);
    check("f4_pend",int'(pend_4), owed[2]);
    check("f4_busy",int'(busy_4), int'(owed[2] > 0));
  endtask

  task automatic step(input bit as, input bit clr, input bit a4);
    a_s   = as;
    clr_s = clr;
    a_4   = a4;
    a_1   = 1'($urandom);
    @(posedge clk);
    model_edge(0, a_s, clr_s);
    model_edge(1, a_1, 1'b0);
    model_edge(2, a_4, 1'b0);
    a1_d2 = a1_d1;
    a1_d1 = a_1;
    #1;
    check_all();
  endtask

  initial begin
    int exp_p [4];
    int exp_b [4];
    int exp_b4 [6];
    bit stream [12];
    int cnt, rises, ovf_first;
    bit prev_b;

    rst = 1'b0; a_s = 0; clr_s = 0; a_1 = 0; a_4 = 0;
    model_reset();
    #12;
    check("rst_b",    int'(b_s),    0);
    check("rst_pend", int'(pend_s), 0);
    check("rst_ovf",  int'(ovf_s),  0);
    check("rst_busy", int'(busy_4), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single token, FACTOR=2
    exp_p = '{2, 1, 0, 0};
    exp_b = '{0, 1, 1, 0};
    step(1, 0, 0);
    check("single_p", int'(pend_s), exp_p[0]);
    check("single_b", int'(b_s),    exp_b[0]);
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0);
      check("single_p", int'(pend_s), exp_p[k]);
      check("single_b", int'(b_s),    exp_b[k]);
    end
    check("single_ovf", int'(ovf_s), 0);

    // Stream 110_011_101_000: 12 pulses in one continuous run
    stream = '{1,1,0,0,1,1,1,0,1,0,0,0};
    cnt = 0; rises = 0; prev_b = 0;
    for (int k = 0; k < 32; k++) begin
      step((k < 12) ? stream[k] : 1'b0, 0, 0);
      if (b_s) cnt++;
      if (b_s && !prev_b) rises++;
      prev_b = b_s;
    end
    check("stream_count", cnt, 12);
    check("stream_runs",  rises, 1);

    // Saturation at MAX_PENDING=7
    ovf_first = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0);
      check("sat_p", int'(pend_s), (k <= 6) ? k + 1 : 7);
      if (ovf_s && ovf_first < 0) ovf_first = k;
    end
    check("sat_ovf_cycle", ovf_first, 7);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      if (b_s) cnt++;
    end
    check("sat_drain", cnt, 7);
    check("sat_sticky", int'(ovf_s), 1);

    // Clear on a quiet edge, then clear colliding with saturation
    step(0, 1, 0);
    check("clr_quiet", int'(ovf_s), 0);
    for (int k = 0; k < 8; k++) step(1, 0, 0);
    check("resat", int'(ovf_s), 1);
    step(1, 1, 0);
    check("clr_vs_set", int'(ovf_s), 1);
    step(0, 1, 0);
    check("clr_after", int'(ovf_s), 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0);

    // Reset mid-burst, FACTOR=4
    step(0, 0, 1);
    step(0, 0, 0);
    check("f4_pre_rst", int'(pend_4), 3);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("arst_b",    int'(b_4),    0);
    check("arst_busy", int'(busy_4), 0);
    check("arst_pend", int'(pend_4), 0);
    check("arst_ovf",  int'(ovf_4),  0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    exp_b4 = '{0, 1, 1, 1, 1, 0};
    for (int k = 0; k < 6; k++) begin
      step(0, 0, (k == 0));
      check("f4_cold_b", int'(b_4), exp_b4[k]);
    end

    // FACTOR=1 random stream
    for (int k = 0; k < 200; k++) step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
